// File: rtl/policy_fifo_pkg.sv
// Shared types and helpers for the overflow-policy FIFO.
package policy_fifo_pkg;

  typedef enum logic {
    DROP_OLDEST = 1'b0,
    DROP_NEWEST = 1'b1
  } ovf_mode_e;

  function automatic int unsigned ptr_inc(
    input int unsigned ptr,
    input int unsigned depth
  );
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/policy_fifo_mem.sv
// Storage array: synchronous write, registered read port.
module policy_fifo_mem #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DWIDTH-1:0] o_rdata
);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Same-slot read and write returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/policy_fifo.sv
// FIFO with run-time drop-oldest / drop-newest overflow policy.
// Lost-word counter built only with POLICY_FIFO_OVF_CNT_EN.
module policy_fifo
  import policy_fifo_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = DEPTH - 1,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       write_en,
  input  logic [DWIDTH-1:0]          wdata,
  input  logic                       read_en,
  input  logic                       mode,
  input  logic                       clr_ovf,
  output logic [DWIDTH-1:0]          rdata,
  output logic                       rvalid,
  output logic                       empty_flg,
  output logic                       full_flg,
  output logic                       afull_flg,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_rvalid, r_empty, r_full, r_afull;

  logic          w_rd_acc, w_wr_store, w_ovf, w_drop_old;
  logic          w_inc, w_dec;
  logic [LW-1:0] w_level_nxt;
  ovf_mode_e     w_mode;

  assign w_mode     = ovf_mode_e'(mode);
  assign w_rd_acc   = read_en && !r_empty;
  assign w_ovf      = write_en && r_full && !w_rd_acc;
  assign w_drop_old = w_ovf && (w_mode == DROP_OLDEST);
  assign w_wr_store = write_en && (!w_ovf || w_drop_old);
  assign w_inc      = w_wr_store && !w_rd_acc && !r_full;
  assign w_dec      = w_rd_acc && !w_wr_store;

  always_comb begin
    w_level_nxt = r_level;
    if (w_inc)      w_level_nxt = r_level + LW'(1);
    else if (w_dec) w_level_nxt = r_level - LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_rvalid <= 1'b0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
    end else begin
      if (w_wr_store)
        r_wr_ptr <= AW'(ptr_inc(32'(r_wr_ptr), DEPTH));
      // Eviction consumes the oldest slot just like a read.
      if (w_rd_acc || w_drop_old)
        r_rd_ptr <= AW'(ptr_inc(32'(r_rd_ptr), DEPTH));
      r_level  <= w_level_nxt;
      r_rvalid <= w_rd_acc;
      r_empty  <= (w_level_nxt == '0);
      r_full   <= (w_level_nxt == LW'(DEPTH));
      r_afull  <= (w_level_nxt >= LW'(AFULL_TH));
    end
  end

  policy_fifo_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr_store),
    .i_waddr (r_wr_ptr),
    .i_wdata (wdata),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (rdata)
  );

`ifdef POLICY_FIFO_OVF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] r_ovf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ovf_cnt <= '0;
    else if (clr_ovf)
      r_ovf_cnt <= w_ovf ? CNT_W'(1) : '0;
    else if (w_ovf && r_ovf_cnt != CNT_MAX)
      r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
  end

  assign ovf_cnt = r_ovf_cnt;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = clr_ovf ^ w_ovf;
  assign ovf_cnt      = '0;
`endif

  assign rvalid    = r_rvalid;
  assign empty_flg = r_empty;
  assign full_flg  = r_full;
  assign afull_flg = r_afull;
  assign level     = r_level;

endmodule

// File: tb/tb_policy_fifo.sv
// Randomised and directed bench for policy_fifo against a queue model.
module tb_policy_fifo;

`ifdef POLICY_FIFO_OVF_CNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       we  [2];
  logic       rde [2];
  logic       md  [2];
  logic       clr [2];
  logic [7:0] wd  [2];

  logic [7:0]  rdata0, rdata1;
  logic        rvalid0, rvalid1, empty0, empty1;
  logic        full0, full1, afull0, afull1;
  logic [2:0]  level0, level1;
  logic [15:0] ovf0;
  logic [2:0]  ovf1;

  policy_fifo #(.DWIDTH(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .write_en(we[0]), .wdata(wd[0]), .read_en(rde[0]),
    .mode(md[0]), .clr_ovf(clr[0]),
    .rdata(rdata0), .rvalid(rvalid0),
    .empty_flg(empty0), .full_flg(full0), .afull_flg(afull0),
    .level(level0), .ovf_cnt(ovf0)
  );

  policy_fifo #(.DWIDTH(8), .DEPTH(5), .AFULL_TH(3), .CNT_W(3)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .write_en(we[1]), .wdata(wd[1]), .read_en(rde[1]),
    .mode(md[1]), .clr_ovf(clr[1]),
    .rdata(rdata1), .rvalid(rvalid1),
    .empty_flg(empty1), .full_flg(full1), .afull_flg(afull1),
    .level(level1), .ovf_cnt(ovf1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of words per instance.
  int unsigned mq [2][$];
  int unsigned m_rd  [2];
  bit          m_rv  [2];
  int unsigned m_ovf [2];
  int unsigned dep  [2] = '{4, 5};
  int unsigned ath  [2] = '{3, 3};
  int unsigned cmax [2] = '{65535, 7};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_rd[i] = 0; m_rv[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic model_step(int i);
    bit full, racc, ovf;
    full = (mq[i].size() == dep[i]);
    racc = rde[i] && (mq[i].size() > 0);
    ovf  = we[i] && full && !racc;
    m_rv[i] = racc;
    if (racc) m_rd[i] = mq[i].pop_front();
    if (we[i]) begin
      if (!ovf) mq[i].push_back(wd[i]);
      else if (md[i] == 1'b0) begin
        void'(mq[i].pop_front());
        mq[i].push_back(wd[i]);
      end
    end
    if (OVF_EN) begin
      if (clr[i]) m_ovf[i] = ovf ? 1 : 0;
      else if (ovf && m_ovf[i] != cmax[i]) m_ovf[i]++;
    end
  endtask

  task automatic check_all(int i);
    logic [7:0] a_rd;
    logic       a_rv, a_e, a_f, a_af;
    logic [2:0] a_lv;
    logic [15:0] a_ov;
    int unsigned n;
    if (i == 0) begin
      a_rd = rdata0; a_rv = rvalid0; a_e = empty0; a_f = full0;
      a_af = afull0; a_lv = level0; a_ov = ovf0;
    end else begin
      a_rd = rdata1; a_rv = rvalid1; a_e = empty1; a_f = full1;
      a_af = afull1; a_lv = level1; a_ov = {13'd0, ovf1};
    end
    n = mq[i].size();
    chk($sformatf("d%0d.rvalid", i), 32'(a_rv), 32'(m_rv[i]));
    chk($sformatf("d%0d.rdata", i), 32'(a_rd), m_rd[i]);
    chk($sformatf("d%0d.level", i), 32'(a_lv), n);
    chk($sformatf("d%0d.empty", i), 32'(a_e), 32'(n == 0));
    chk($sformatf("d%0d.full", i), 32'(a_f), 32'(n == dep[i]));
    chk($sformatf("d%0d.afull", i), 32'(a_af), 32'(n >= ath[i]));
    chk($sformatf("d%0d.ovf", i), 32'(a_ov), m_ovf[i]);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      we[i] = 0; rde[i] = 0; md[i] = 0; clr[i] = 0; wd[i] = '0;
    end
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all(0);
    check_all(1);
  endtask

  task automatic op(int i, bit w, logic [7:0] d, bit r, bit m);
    idle_inputs();
    we[i] = w; wd[i] = d; rde[i] = r; md[i] = m;
    cycle();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all(0);
    check_all(1);
    chk("rst.empty", 32'(empty0), 1);
    rst_n = 1'b1;

    // Drop-oldest: 0..5 then 4 reads -> 2,3,4,5
    for (int k = 0; k < 6; k++) op(0, 1, 8'(k), 0, 0);
    for (int k = 0; k < 4; k++) begin
      op(0, 0, 0, 1, 0);
      chk("s2.rdata", 32'(rdata0), 32'(k + 2));
    end
    chk("s2.empty", 32'(empty0), 1);
    chk("s2.ovf", 32'(ovf0), OVF_EN ? 2 : 0);

    // Drop-newest: 0..5 then 4 reads -> 0,1,2,3
    idle_inputs(); clr[0] = 1; cycle();
    for (int k = 0; k < 6; k++) begin
      op(0, 1, 8'(k), 0, 1);
      if (k == 3) chk("s3.full", 32'(full0), 1);
    end
    for (int k = 0; k < 4; k++) begin
      op(0, 0, 0, 1, 1);
      chk("s3.rdata", 32'(rdata0), 32'(k));
    end
    chk("s3.ovf", 32'(ovf0), OVF_EN ? 2 : 0);

    // Full + simultaneous write/read
    for (int k = 0; k < 4; k++) op(0, 1, 8'(k), 0, 1);
    op(0, 1, 8'hAA, 1, 1);
    chk("s4.rdata", 32'(rdata0), 0);
    chk("s4.level", 32'(level0), 4);
    for (int k = 1; k < 4; k++) op(0, 0, 0, 1, 0);
    op(0, 0, 0, 1, 0);
    chk("s4.last", 32'(rdata0), 32'hAA);

    // Empty read, then write+read on empty
    op(0, 0, 0, 1, 0);
    chk("s5.rvalid", 32'(rvalid0), 0);
    op(0, 1, 8'h55, 1, 0);
    chk("s5.level", 32'(level0), 1);
    op(0, 0, 0, 1, 0);
    chk("s5.rdata", 32'(rdata0), 32'h55);

    // DEPTH=5 wrap and almost-full
    for (int k = 0; k < 3; k++) op(1, 1, 8'(8'h10 + k), 0, 0);
    chk("s6.afull", 32'(afull1), 1);
    for (int k = 0; k < 3; k++) op(1, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) op(1, 1, 8'(8'h20 + k), 0, 0);
    for (int k = 0; k < 7; k++) op(1, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) op(1, 1, 8'(8'h30 + k), 0, 0);
    for (int k = 0; k < 3; k++) op(1, 0, 0, 1, 0);
    chk("s6.rdata", 32'(rdata1), 32'h32);
    for (int k = 0; k < 3; k++) op(1, 1, 8'(8'h40 + k), 0, 0);

    // Asynchronous reset mid-operation
    idle_inputs();
    we[0] = 1; wd[0] = 8'h77; we[1] = 1; wd[1] = 8'h78;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(0);
    check_all(1);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    // Random traffic on both instances
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        we[i]  = ($urandom_range(0, 9) < 6);
        rde[i] = ($urandom_range(0, 9) < 5);
        md[i]  = 1'($urandom_range(0, 1));
        clr[i] = ($urandom_range(0, 24) == 0);
        wd[i]  = 8'($urandom);
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
